// File: rtl/idma_2d_rsp_merge_pkg.sv
// -----------------------------------------------------------------------------
// idma_2d_rsp_merge_pkg
// Shared definitions for the 2D response merge block.
//   - state_e  : merge FSM states (IDLE / COUNT / RESP)
//   - DEF_*    : default widths/depth used by the merge top and its FIFO
// The width-dependent records (expectation {id, num} and 2D completion
// {id, error, err_cnt}) are declared inside the top so that they follow its
// ID_WIDTH / CNT_WIDTH parameters.
// -----------------------------------------------------------------------------
package idma_2d_rsp_merge_pkg;

    localparam int unsigned DEF_ID_WIDTH       = 4;
    localparam int unsigned DEF_CNT_WIDTH      = 32;
    localparam int unsigned DEF_EXP_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/idma_2d_rsp_merge_fifo.sv
// -----------------------------------------------------------------------------
// idma_2d_rsp_merge_fifo
// Synchronous FIFO for transfer expectations. The head is read straight from
// storage, so an entry written in cycle t is first visible in cycle t+1.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (clears pointers)
//   i_push, i_data    write strobe and data; caller guarantees !o_full
//   i_pop             read strobe; caller guarantees !o_empty
//   o_data            current head entry
//   o_full, o_empty   occupancy flags
//   o_usage           number of stored entries
// -----------------------------------------------------------------------------
module idma_2d_rsp_merge_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_usage
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned USE_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [USE_W-1:0] r_usage;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH-1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_usage <= r_usage + 1'b1;
                2'b01:   r_usage <= r_usage - 1'b1;
                default: r_usage <= r_usage;
            endcase
        end
    end

    // Storage is data only; validity is carried by the pointers and usage.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_usage == USE_W'(DEPTH));
    assign o_empty = (r_usage == '0);
    assign o_usage = r_usage;

endmodule

// File: rtl/idma_2d_rsp_merge.sv
// -----------------------------------------------------------------------------
// idma_2d_rsp_merge
// Collects the per-burst backend responses of each flattened 2D transfer and
// emits one completion per transfer, in expectation order.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   exp_valid_i/exp_ready_o      expectation handshake (ready = FIFO not full)
//   exp_id_i, exp_num_i          transfer id and number of 1D bursts
//   burst_rsp_valid_i/_ready_o   backend burst response handshake
//   burst_rsp_error_i            burst finished with error
//   twod_rsp_valid_o/_ready_i    2D completion handshake
//   twod_rsp_id_o                id of the completed transfer
//   twod_rsp_error_o             OR of the burst errors of the transfer
//   twod_rsp_err_cnt_o           number of erroneous bursts (saturating)
//   unexpected_o                 sticky: burst seen with nothing outstanding
// -----------------------------------------------------------------------------
module idma_2d_rsp_merge #(
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned EXP_FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  exp_valid_i,
    output logic                  exp_ready_o,
    input  logic [ID_WIDTH-1:0]   exp_id_i,
    input  logic [CNT_WIDTH-1:0]  exp_num_i,
    input  logic                  burst_rsp_valid_i,
    output logic                  burst_rsp_ready_o,
    input  logic                  burst_rsp_error_i,
    output logic                  twod_rsp_valid_o,
    input  logic                  twod_rsp_ready_i,
    output logic [ID_WIDTH-1:0]   twod_rsp_id_o,
    output logic                  twod_rsp_error_o,
    output logic [CNT_WIDTH-1:0]  twod_rsp_err_cnt_o,
    output logic                  unexpected_o
);

    import idma_2d_rsp_merge_pkg::*;

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [CNT_WIDTH-1:0] num;
    } exp_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic                 error;
        logic [CNT_WIDTH-1:0] err_cnt;
    } twod_rsp_t;

    localparam int unsigned USE_W = $clog2(EXP_FIFO_DEPTH+1);

    state_e               r_state;
    state_e               w_state_next;
    logic [CNT_WIDTH-1:0] r_rem;
    twod_rsp_t            r_rsp;
    logic                 r_unexpected;

    exp_t                 w_exp_in;
    exp_t                 w_exp_head;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [USE_W-1:0]     w_fifo_usage;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_burst_hs;
    logic                 w_burst_ready;
    logic                 w_twod_valid;

    // Error counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v,
        input logic                 inc
    );
        if (inc && (v != '1)) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    assign w_exp_in.id  = exp_id_i;
    assign w_exp_in.num = exp_num_i;

    assign exp_ready_o = !w_fifo_full;
    assign w_push      = exp_valid_i & exp_ready_o;
    // IDLE consumes the head every cycle it is present, including num==0 drops.
    assign w_pop       = (r_state == ST_IDLE) && (w_fifo_usage != '0);
    assign w_burst_hs  = burst_rsp_valid_i & w_burst_ready;

    idma_2d_rsp_merge_fifo #(
        .WIDTH (ID_WIDTH + CNT_WIDTH),
        .DEPTH (EXP_FIFO_DEPTH)
    ) u_exp_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_data  (w_exp_in),
        .i_pop   (w_pop),
        .o_data  (w_exp_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_usage (w_fifo_usage)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop && (w_exp_head.num != '0)) begin
                    w_state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_burst_hs && (r_rem == CNT_WIDTH'(1))) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (twod_rsp_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode. Bursts are accepted in IDLE only when nothing is queued,
    // so that stray responses are drained and flagged instead of stalling.
    always_comb begin
        w_burst_ready = 1'b0;
        w_twod_valid  = 1'b0;
        case (r_state)
            ST_IDLE:  w_burst_ready = w_fifo_empty;
            ST_COUNT: w_burst_ready = 1'b1;
            ST_RESP:  w_twod_valid  = 1'b1;
            default: begin
                w_burst_ready = 1'b0;
                w_twod_valid  = 1'b0;
            end
        endcase
    end

    // Transfer bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rem        <= '0;
            r_rsp        <= '0;
            r_unexpected <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_pop && (w_exp_head.num != '0)) begin
                r_rem         <= w_exp_head.num;
                r_rsp.id      <= w_exp_head.id;
                r_rsp.error   <= 1'b0;
                r_rsp.err_cnt <= '0;
            end else if ((r_state == ST_COUNT) && w_burst_hs) begin
                r_rem         <= r_rem - 1'b1;
                r_rsp.error   <= r_rsp.error | burst_rsp_error_i;
                r_rsp.err_cnt <= sat_inc(r_rsp.err_cnt, burst_rsp_error_i);
            end
            if ((r_state == ST_IDLE) && w_fifo_empty && w_burst_hs) begin
                r_unexpected <= 1'b1;
            end
        end
    end

    assign burst_rsp_ready_o  = w_burst_ready;
    assign twod_rsp_valid_o   = w_twod_valid;
    assign twod_rsp_id_o      = r_rsp.id;
    assign twod_rsp_error_o   = r_rsp.error;
    assign twod_rsp_err_cnt_o = r_rsp.err_cnt;
    assign unexpected_o       = r_unexpected;

endmodule

// File: tb/tb_idma_2d_rsp_merge.sv
// -----------------------------------------------------------------------------
// tb_idma_2d_rsp_merge
// Directed and randomized stimulus for idma_2d_rsp_merge, checked against a
// transaction-level model: expectations and burst errors go into queues, and
// each completed transfer yields {id, OR of errors, count of errors}.
// -----------------------------------------------------------------------------
module tb_idma_2d_rsp_merge;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned DEPTH = 4;
    localparam int          WAIT_LIMIT = 100;

    logic             clk;
    logic             rst_i;
    logic             exp_valid_i;
    logic             exp_ready_o;
    logic [ID_W-1:0]  exp_id_i;
    logic [CNT_W-1:0] exp_num_i;
    logic             burst_rsp_valid_i;
    logic             burst_rsp_ready_o;
    logic             burst_rsp_error_i;
    logic             twod_rsp_valid_o;
    logic             twod_rsp_ready_i;
    logic [ID_W-1:0]  twod_rsp_id_o;
    logic             twod_rsp_error_o;
    logic [CNT_W-1:0] twod_rsp_err_cnt_o;
    logic             unexpected_o;

    idma_2d_rsp_merge #(
        .ID_WIDTH       (ID_W),
        .CNT_WIDTH      (CNT_W),
        .EXP_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .exp_valid_i        (exp_valid_i),
        .exp_ready_o        (exp_ready_o),
        .exp_id_i           (exp_id_i),
        .exp_num_i          (exp_num_i),
        .burst_rsp_valid_i  (burst_rsp_valid_i),
        .burst_rsp_ready_o  (burst_rsp_ready_o),
        .burst_rsp_error_i  (burst_rsp_error_i),
        .twod_rsp_valid_o   (twod_rsp_valid_o),
        .twod_rsp_ready_i   (twod_rsp_ready_i),
        .twod_rsp_id_o      (twod_rsp_id_o),
        .twod_rsp_error_o   (twod_rsp_error_o),
        .twod_rsp_err_cnt_o (twod_rsp_err_cnt_o),
        .unexpected_o       (unexpected_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [ID_W-1:0] id;
        int              num;
    } mexp_t;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } mcmp_t;

    mexp_t exp_q[$];
    mcmp_t cmp_q[$];
    bit    cur_errs[$];
    bit    m_unexp;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cmp_q.delete();
        cur_errs.delete();
        m_unexp = 1'b0;
    endtask

    task automatic model_burst(input bit err);
        mcmp_t c;
        while (exp_q.size() > 0 && exp_q[0].num == 0) begin
            void'(exp_q.pop_front());
        end
        if (exp_q.size() == 0) begin
            m_unexp = 1'b1;
            return;
        end
        cur_errs.push_back(err);
        if (cur_errs.size() == exp_q[0].num) begin
            c.id  = exp_q[0].id;
            c.err = 1'b0;
            c.cnt = '0;
            foreach (cur_errs[k]) begin
                c.err = c.err | cur_errs[k];
                c.cnt = c.cnt + 32'(cur_errs[k]);
            end
            cmp_q.push_back(c);
            void'(exp_q.pop_front());
            cur_errs.delete();
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [ID_W-1:0] id, input int num);
        mexp_t e;
        int n;
        exp_valid_i = 1'b1;
        exp_id_i    = id;
        exp_num_i   = 32'(num);
        n = 0;
        while (!exp_ready_o && n < WAIT_LIMIT) begin
            step();
            n++;
        end
        chk("exp_wait", 32'(n < WAIT_LIMIT), 32'd1);
        step();
        exp_valid_i = 1'b0;
        e.id  = id;
        e.num = num;
        exp_q.push_back(e);
    endtask

    task automatic send_burst(input bit err);
        int n;
        burst_rsp_valid_i = 1'b1;
        burst_rsp_error_i = err;
        n = 0;
        while (!burst_rsp_ready_o && n < WAIT_LIMIT) begin
            step();
            n++;
        end
        chk("burst_wait", 32'(n < WAIT_LIMIT), 32'd1);
        step();
        burst_rsp_valid_i = 1'b0;
        burst_rsp_error_i = 1'b0;
        model_burst(err);
    endtask

    task automatic expect_completion(input int hold);
        mcmp_t c;
        int n;
        n = 0;
        while (!twod_rsp_valid_o && n < WAIT_LIMIT) begin
            step();
            n++;
        end
        chk("cmp_wait", 32'(n < WAIT_LIMIT), 32'd1);
        chk("cmp_model_avail", 32'(cmp_q.size() > 0), 32'd1);
        if (cmp_q.size() == 0) begin
            return;
        end
        c = cmp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            chk("cmp_valid", 32'(twod_rsp_valid_o), 32'd1);
            chk("cmp_id", 32'(twod_rsp_id_o), 32'(c.id));
            chk("cmp_error", 32'(twod_rsp_error_o), 32'(c.err));
            chk("cmp_err_cnt", twod_rsp_err_cnt_o, c.cnt);
            chk("cmp_burst_rdy_low", 32'(burst_rsp_ready_o), 32'd0);
            if (h < hold) begin
                step();
            end
        end
        twod_rsp_ready_i = 1'b1;
        step();
        twod_rsp_ready_i = 1'b0;
        chk("cmp_retired", 32'(twod_rsp_valid_o), 32'd0);
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_exp_ready"}, 32'(exp_ready_o), 32'd1);
        chk({tag, "_burst_ready"}, 32'(burst_rsp_ready_o), 32'd1);
        chk({tag, "_valid"}, 32'(twod_rsp_valid_o), 32'd0);
        chk({tag, "_id"}, 32'(twod_rsp_id_o), 32'd0);
        chk({tag, "_error"}, 32'(twod_rsp_error_o), 32'd0);
        chk({tag, "_err_cnt"}, twod_rsp_err_cnt_o, 32'd0);
        chk({tag, "_unexpected"}, 32'(unexpected_o), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_i             = 1'b1;
        exp_valid_i       = 1'b0;
        exp_id_i          = '0;
        exp_num_i         = '0;
        burst_rsp_valid_i = 1'b0;
        burst_rsp_error_i = 1'b0;
        twod_rsp_ready_i  = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        // burst ready is high here because IDLE with an empty FIFO drains strays
        check_idle_outputs("reset");

        // transfer id=3, four clean bursts; completion one cycle after last burst
        push_exp(4'd3, 4);
        for (int i = 0; i < 4; i++) begin
            send_burst(1'b0);
        end
        chk("t1_latency", 32'(twod_rsp_valid_o), 32'd1);
        expect_completion(0);

        // transfer id=5, errors 0,1,1; completion held for 5 cycles
        push_exp(4'd5, 3);
        send_burst(1'b0);
        send_burst(1'b1);
        send_burst(1'b1);
        chk("t2_latency", 32'(twod_rsp_valid_o), 32'd1);
        expect_completion(5);

        // zero-burst expectation is discarded without a completion
        push_exp(4'd1, 0);
        push_exp(4'd2, 1);
        send_burst(1'b0);
        expect_completion(0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_no_extra", 32'(twod_rsp_valid_o), 32'd0);
        end

        // FIFO fill while a completion is held back
        push_exp(4'd9, 1);
        send_burst(1'b1);
        for (int i = 0; i < 4; i++) begin
            push_exp(4'(10 + i), 2);
        end
        chk("t4_full_exp_ready", 32'(exp_ready_o), 32'd0);
        expect_completion(0);
        for (int i = 0; i < 4; i++) begin
            send_burst(1'($urandom_range(0, 1)));
            send_burst(1'($urandom_range(0, 1)));
            expect_completion(0);
        end
        chk("t4_exp_ready_back", 32'(exp_ready_o), 32'd1);

        // stray burst with nothing outstanding
        step();
        chk("t5_burst_ready", 32'(burst_rsp_ready_o), 32'd1);
        send_burst(1'b1);
        chk("t5_unexpected", 32'(unexpected_o), 32'(m_unexp));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_cmp", 32'(twod_rsp_valid_o), 32'd0);
        end

        // randomized transfers
        for (int it = 0; it < 12; it++) begin
            logic [ID_W-1:0] rid;
            int rnum;
            rid  = 4'($urandom_range(0, 15));
            rnum = int'($urandom_range(0, 3));
            push_exp(rid, rnum);
            for (int b = 0; b < rnum; b++) begin
                send_burst(1'($urandom_range(0, 1)));
            end
            if (rnum > 0) begin
                expect_completion(int'($urandom_range(0, 2)));
            end
        end
        step();
        step();
        chk("rnd_unexpected_sticky", 32'(unexpected_o), 32'(m_unexp));
        chk("rnd_no_pending", 32'(twod_rsp_valid_o), 32'd0);

        // reset in the middle of a transfer
        push_exp(4'd6, 4);
        send_burst(1'b1);
        send_burst(1'b0);
        apply_reset();
        check_idle_outputs("t6_reset");
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_no_cmp", 32'(twod_rsp_valid_o), 32'd0);
        end
        push_exp(4'd7, 1);
        send_burst(1'b1);
        expect_completion(1);
        chk("t6_unexpected_clear", 32'(unexpected_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
